// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    // Width of the per-button tick counter; bounds DEBOUNCE_MS and the repeat periods.
    localparam int BTN_CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        GAP,
        DB_REL
    } btn_state_t;

    // Saturating increment so a long hold never wraps back into a match.
    function automatic logic [BTN_CNT_W-1:0] cnt_inc_sat(input logic [BTN_CNT_W-1:0] c);
        return (c == {BTN_CNT_W{1'b1}}) ? c : c + BTN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchronizer, polarity fix, debounce/auto-repeat FSM with
// a tick counter, and registered level and press-pulse outputs.
module button_channel
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_MS     = 20,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam logic [BTN_CNT_W-1:0] DB_CNT    = BTN_CNT_W'(DEBOUNCE_MS);
    localparam logic [BTN_CNT_W-1:0] DELAY_CNT = BTN_CNT_W'(REPEAT_DELAY_MS);
    localparam logic [BTN_CNT_W-1:0] RATE_CNT  = BTN_CNT_W'(REPEAT_RATE_MS);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 pressed;
    btn_state_t           state_q, state_d;
    logic [BTN_CNT_W-1:0] cnt_q, cnt_d;
    logic [BTN_CNT_W-1:0] cnt_inc;
    logic                 rep_q, rep_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;

    // Two-stage synchronizer; resets to the released pin level so no false press follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ ACTIVE_LOW;

    // Next-state logic: debounce on press/release, periodic one-tick gaps while held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        press_d = 1'b0;
        cnt_inc = cnt_inc_sat(cnt_q);
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        rep_d   = 1'b0;
                        press_d = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (REPEAT_EN && (cnt_inc == (rep_q ? RATE_CNT : DELAY_CNT))) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // A release during the gap is taken at once: the level is already low.
                if (!pressed) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    rep_d   = 1'b1;
                    press_d = 1'b1;
                end
            end
            DB_REL: begin
                // A bounce back to pressed restarts the repeat timer but keeps the rep phase.
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == HELD) || (state_d == DB_REL);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: shared 1 ms tick prescaler feeding N_BTN independent
// synchronize/debounce/auto-repeat channels.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 8,
    parameter int CLK_HZ          = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_MS     = 20,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_export,
    output logic [N_BTN-1:0] btn_press
);

    localparam int             TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int             PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    // Prescaler: tick is the terminal count, after which the counter wraps to 0.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_export[i]),
            .btn_press (btn_press[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (auto-repeat on and off) share the
// stimulus and are compared each cycle against a behavioural model.
module tb_button_conditioner;

    localparam int TICK_CYC = 10;
    localparam int DB       = 4;
    localparam int DELAY    = 20;
    localparam int RATE     = 5;

    logic       clk;
    logic       reset_n;
    logic [7:0] btn_raw;
    logic [7:0] exp_a, prs_a, exp_b, prs_b;

    int checks;
    int failures;

    typedef struct packed {
        bit acc;
        bit gap;
        bit armed;
        bit rel_armed;
        bit rep;
        int cnt;
        int hold;
    } mdl_t;

    mdl_t       mdl [2][8];
    bit         r1 [8];
    bit         r2 [8];
    int         edges;
    logic [7:0] m_exp [2];
    logic [7:0] m_prs [2];

    button_conditioner #(
        .N_BTN(8), .CLK_HZ(10000), .ACTIVE_LOW(1'b1), .DEBOUNCE_MS(DB),
        .REPEAT_EN(1'b1), .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .btn_export(exp_a), .btn_press(prs_a)
    );

    button_conditioner #(
        .N_BTN(8), .CLK_HZ(10000), .ACTIVE_LOW(1'b1), .DEBOUNCE_MS(DB),
        .REPEAT_EN(1'b0), .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)
    ) u_dut_norep (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .btn_export(exp_b), .btn_press(prs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-level model: a press or release is accepted once the input has stayed
    // put over DB ticks (ticks seen after the first cycle of the new level); while
    // accepted, the level drops for one tick after DELAY ticks, then every RATE ticks.
    function automatic mdl_t mstep(input mdl_t m_in, input bit p, input bit t, input bit ren,
                                   output bit prs);
        mdl_t m;
        m   = m_in;
        prs = 1'b0;
        if (!m.acc) begin
            if (!p) begin
                m.armed = 1'b0;
                m.cnt   = 0;
            end else if (!m.armed) begin
                m.armed = 1'b1;
                m.cnt   = 0;
            end else if (t) begin
                m.cnt = m.cnt + 1;
                if (m.cnt == DB) begin
                    m.acc = 1'b1; m.gap = 1'b0; m.hold = 0; m.rep = 1'b0;
                    m.armed = 1'b0; m.rel_armed = 1'b0; prs = 1'b1;
                end
            end
        end else if (m.gap) begin
            if (!p) begin
                m.acc = 1'b0; m.gap = 1'b0; m.armed = 1'b0;
            end else if (t) begin
                m.gap = 1'b0; m.hold = 0; m.rep = 1'b1; prs = 1'b1;
            end
        end else if (!p) begin
            if (!m.rel_armed) begin
                m.rel_armed = 1'b1;
                m.cnt       = 0;
            end else if (t) begin
                m.cnt = m.cnt + 1;
                if (m.cnt == DB) begin
                    m.acc = 1'b0; m.rel_armed = 1'b0; m.armed = 1'b0;
                end
            end
        end else begin
            if (m.rel_armed) begin
                m.rel_armed = 1'b0;
                m.hold      = 0;
            end else if (t) begin
                m.hold = m.hold + 1;
                if (ren && (m.hold == (m.rep ? RATE : DELAY))) m.gap = 1'b1;
            end
        end
        return m;
    endfunction

    initial begin : model
        bit t, p, pb;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                edges = 0;
                for (int i = 0; i < 8; i++) begin
                    r1[i] = 1'b1;
                    r2[i] = 1'b1;
                    for (int k = 0; k < 2; k++) mdl[k][i] = '0;
                end
                m_exp[0] = '0; m_exp[1] = '0; m_prs[0] = '0; m_prs[1] = '0;
            end else begin
                t     = ((edges % TICK_CYC) == TICK_CYC - 1);
                edges = edges + 1;
                for (int i = 0; i < 8; i++) begin
                    p = ~r2[i];
                    for (int k = 0; k < 2; k++) begin
                        mdl[k][i]   = mstep(mdl[k][i], p, t, (k == 0), pb);
                        m_prs[k][i] = pb;
                        m_exp[k][i] = mdl[k][i].acc & ~mdl[k][i].gap;
                    end
                    r2[i] = r1[i];
                    r1[i] = btn_raw[i];
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time=%0t limit reached before summary", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        btn_raw = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({exp_a, prs_a, exp_b, prs_b} !== 32'h0) begin
            failures++;
            $display("FAIL reset_state export=%h/%h press=%h/%h required all 00", exp_a, exp_b, prs_a, prs_b);
        end
        reset_n = 1'b1;
        repeat (500) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== 32'h0) begin
                failures++;
                $display("FAIL reset_idle t=%0t export=%h/%h press=%h/%h required all 00", $time, exp_a, exp_b, prs_a, prs_b);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses, rise;
        pulses = 0;
        rise   = -1;
        for (int k = 0; k < 20; k++) begin
            btn_raw[0] = ~btn_raw[0];
            repeat (3) begin
                @(negedge clk);
                checks++;
                if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                    failures++;
                    $display("FAIL bounce_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
                end
                if (prs_a[0]) pulses++;
            end
        end
        btn_raw[0] = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL bounce_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            if (prs_a[0]) pulses++;
            if (exp_a[0] && rise < 0) rise = c;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL bounce_pulses got=%0d required=1", pulses);
        end
        checks++;
        if (rise < 32 || rise > 52) begin
            failures++;
            $display("FAIL bounce_latency got=%0d required 32..52 cycles", rise);
        end
        btn_raw[0] = 1'b1;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL bounce_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    task automatic test_autorepeat();
        int pt[$];
        bit hist [0:400];
        int nb;
        nb         = 0;
        hist[0]    = exp_a[2];
        btn_raw[2] = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL repeat_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            hist[c] = exp_a[2];
            if (prs_a[2]) pt.push_back(c);
            if (prs_b[2]) nb++;
        end
        checks++;
        if (pt.size() !== 4) begin
            failures++;
            $display("FAIL repeat_count got=%0d required=4", pt.size());
        end else begin
            checks++;
            if (pt[1] - pt[0] !== 210) begin
                failures++;
                $display("FAIL repeat_first_spacing got=%0d required=210", pt[1] - pt[0]);
            end
            checks++;
            if (pt[2] - pt[1] !== 60) begin
                failures++;
                $display("FAIL repeat_rate_1 got=%0d required=60", pt[2] - pt[1]);
            end
            checks++;
            if (pt[3] - pt[2] !== 60) begin
                failures++;
                $display("FAIL repeat_rate_2 got=%0d required=60", pt[3] - pt[2]);
            end
            for (int r = 1; r < 4; r++) begin
                bit ok;
                ok = hist[pt[r]] && hist[pt[r] - 11];
                for (int j = 1; j <= 10; j++) if (hist[pt[r] - j]) ok = 1'b0;
                checks++;
                if (ok !== 1'b1) begin
                    failures++;
                    $display("FAIL repeat_gap pulse=%0d got gap shape bad required 10 low cycles before pulse", r);
                end
            end
        end
        checks++;
        if (nb !== 1) begin
            failures++;
            $display("FAIL norep_bit2_pulses got=%0d required=1", nb);
        end
        btn_raw[2] = 1'b1;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL repeat_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    task automatic test_release_glitch();
        bit got;
        int pulses, fall;
        got        = 1'b0;
        pulses     = 0;
        fall       = -1;
        btn_raw[1] = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL glitch_press_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            if (exp_a[1]) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL glitch_accept_timeout got export[1]=%b required 1 within 80 cycles", exp_a[1]);
        end
        for (int ph = 0; ph < 3; ph++) begin
            btn_raw[1] = (ph == 1);
            repeat ((ph == 0) ? 20 : (ph == 1) ? 25 : 30) begin
                @(negedge clk);
                checks++;
                if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                    failures++;
                    $display("FAIL glitch_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
                end
                checks++;
                if (exp_a[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL glitch_level t=%0t got=%b required=1", $time, exp_a[1]);
                end
                if (prs_a[1]) pulses++;
            end
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL glitch_extra_press got=%0d required=0", pulses);
        end
        btn_raw[1] = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL glitch_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            if (!exp_a[1] && fall < 0) fall = c;
        end
        checks++;
        if (fall < 32 || fall > 52) begin
            failures++;
            $display("FAIL release_latency got=%0d required 32..52 cycles", fall);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        btn_raw[0] = 1'b0;
        btn_raw[7] = 1'b0;
        repeat (300) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL simul_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            checks++;
            if ({exp_a[7], prs_a[7], exp_a[6:1], prs_a[6:1]} !== {exp_a[0], prs_a[0], 12'h000}) begin
                failures++;
                $display("FAIL simul_match t=%0t export=%h press=%h required bits 0/7 equal, 6:1 zero", $time, exp_a, prs_a);
            end
            if (prs_a[0]) pulses++;
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL simul_pulses got=%0d required=2", pulses);
        end
        btn_raw[0] = 1'b1;
        btn_raw[7] = 1'b1;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL simul_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    task automatic test_repeat_disabled();
        int  pulses;
        bit  seen;
        pulses     = 0;
        seen       = 1'b0;
        btn_raw[3] = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL norep_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            if (prs_b[3]) pulses++;
            if (seen) begin
                checks++;
                if (exp_b[3] !== 1'b1) begin
                    failures++;
                    $display("FAIL norep_level t=%0t got=%b required=1", $time, exp_b[3]);
                end
            end
            if (exp_b[3]) seen = 1'b1;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL norep_pulses got=%0d required=1", pulses);
        end
        btn_raw[3] = 1'b1;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL norep_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    task automatic test_random();
        int left [8];
        for (int i = 0; i < 8; i++) left[i] = int'($urandom_range(120, 1));
        repeat (4000) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL random_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            for (int i = 0; i < 8; i++) begin
                left[i] = left[i] - 1;
                if (left[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    if ($urandom_range(3, 0) == 0) left[i] = int'($urandom_range(8, 1));
                    else                           left[i] = int'($urandom_range(300, 20));
                end
            end
        end
        btn_raw = 8'hFF;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL random_release_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit got;
        got        = 1'b0;
        btn_raw[0] = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL midreset_press_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
            if (exp_a[0]) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL midreset_accept_timeout got export[0]=%b required 1 within 80 cycles", exp_a[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({exp_a, prs_a, exp_b, prs_b} !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async export=%h/%h press=%h/%h required all 00", exp_a, exp_b, prs_a, prs_b);
        end
        @(negedge clk);
        btn_raw = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if ({exp_a, prs_a, exp_b, prs_b} !== {m_exp[0], m_prs[0], m_exp[1], m_prs[1]}) begin
                failures++;
                $display("FAIL midreset_after_model t=%0t export=%h/%h press=%h/%h required export=%h/%h press=%h/%h", $time, exp_a, exp_b, prs_a, prs_b, m_exp[0], m_exp[1], m_prs[0], m_prs[1]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        btn_raw  = 8'hFF;
        test_reset();
        test_bounce();
        test_autorepeat();
        test_release_glitch();
        test_simultaneous();
        test_repeat_disabled();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
